// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer and its opcode classifier.
package rv32_ctrl_pkg;

    localparam int TMO_W = 10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OP_IMM = 4'd8,
        CLS_OP     = 4'd9
    } instr_class_e;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM    = 2'd2;
    localparam logic [1:0] TRAP_DMEM    = 2'd3;

    // Only register-register ALU ops and branch compares take operand B from rs2.
    function automatic logic uses_imm(input instr_class_e cls);
        logic r;
        case (cls)
            CLS_OP, CLS_BRANCH: r = 1'b0;
            default:            r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode/func3 classifier; flags encodings the core cannot execute.
module opcode_classifier
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   func3,
    output instr_class_e instr_class,
    output logic         illegal
);

    // Map opcode to class; func3 only disqualifies JALR and unsupported load/store widths.
    always_comb begin
        instr_class = CLS_NONE;
        illegal     = 1'b0;
        case (opcode)
            OPC_LUI:    instr_class = CLS_LUI;
            OPC_AUIPC:  instr_class = CLS_AUIPC;
            OPC_JAL:    instr_class = CLS_JAL;
            OPC_JALR: begin
                instr_class = CLS_JALR;
                illegal     = (func3 != 3'd0);
            end
            OPC_BRANCH: instr_class = CLS_BRANCH;
            OPC_LOAD: begin
                instr_class = CLS_LOAD;
                illegal     = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
            end
            OPC_STORE: begin
                instr_class = CLS_STORE;
                illegal     = (func3 > 3'd2);
            end
            OPC_OP_IMM: instr_class = CLS_OP_IMM;
            OPC_OP:     instr_class = CLS_OP;
            default: begin
                instr_class = CLS_NONE;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback with
// memory-timeout and illegal-instruction traps plus a retired-instruction counter.
module multicycle_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 branch_taken,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 clear_trap,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_imm,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic [2:0]           state,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    instr_class_e         cls_q, cls_d;
    logic [1:0]           cause_q, cause_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    instr_class_e cls_s;
    logic         illegal_s;
    logic         retire_s;
    logic         waiting_s;
    state_e       after_retire_s;

    opcode_classifier u_classifier (
        .opcode      (opcode),
        .func3       (func3),
        .instr_class (cls_s),
        .illegal     (illegal_s)
    );

    // Next-state and Moore strobes; run only matters in IDLE and at retirement.
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        cause_d        = cause_q;
        retire_s       = 1'b0;
        waiting_s      = 1'b0;
        after_retire_s = run ? ST_FETCH : ST_IDLE;
        imem_req       = 1'b0;
        ir_write       = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        reg_write      = 1'b0;
        wb_sel         = WB_ALU;
        alu_src_imm    = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PC_PLUS4;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
                else     state_d = ST_IDLE;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_IMEM;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            ST_DECODE: begin
                cls_d = cls_s;
                if (illegal_s) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_src_imm = uses_imm(cls_q);
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                        retire_s = 1'b1;
                        state_d  = after_retire_s;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire_s = 1'b1;
                        state_d  = after_retire_s;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DMEM;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire_s  = 1'b1;
                state_d   = after_retire_s;
                case (cls_q)
                    CLS_LOAD: begin
                        wb_sel = WB_LOAD;
                        pc_src = PC_PLUS4;
                    end
                    CLS_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_REG;
                    end
                    default: begin
                        wb_sel = WB_ALU;
                        pc_src = PC_PLUS4;
                    end
                endcase
            end
            ST_TRAP: begin
                if (clear_trap) begin
                    state_d = ST_IDLE;
                    cause_d = TRAP_NONE;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            default: begin
                // Unused encoding 7: recover to a quiet state.
                state_d = ST_IDLE;
                cause_d = TRAP_NONE;
            end
        endcase
    end

    // Timeout counter restarts on any state change; instret wraps naturally.
    always_comb begin
        if (state_d != state_q) tmo_d = '0;
        else if (waiting_s)     tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        else                    tmo_d = tmo_q;
        if (retire_s) instret_d = instret_q + INSTRET_ONE;
        else          instret_d = instret_q;
    end

    // State, class, cause, timeout and retire-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_NONE;
            cause_q   <= TRAP_NONE;
            tmo_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
            instret_q <= instret_d;
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each scenario queues per-cycle stimulus with expected outputs, then replays it.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, clear_trap = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic       imem_req, ir_write, dmem_req, dmem_we, reg_write, alu_src_imm, pc_write;
    logic [1:0] wb_sel, pc_src, trap_cause;
    logic [2:0] state;
    logic [3:0] instret;
    logic [19:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]  ctl;   // {run, imem_ack, dmem_ack, branch_taken, clear_trap}
        logic [31:0] instr;
        logic [19:0] exp;
    } step_t;
    step_t sb[$];

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0000A023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_JALR = 32'h00000067;

    multicycle_control_fsm #(.INSTRET_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3),
        .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .clear_trap(clear_trap), .imem_req(imem_req), .ir_write(ir_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_imm(alu_src_imm), .pc_write(pc_write), .pc_src(pc_src), .state(state),
        .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel,
                  alu_src_imm, pc_write, pc_src, trap_cause, instret};

    function automatic logic [19:0] ov(input logic [2:0] st, input logic imreq, irw, dreq, dwe, rw,
                                       input logic [1:0] wbs, input logic alu, pcw,
                                       input logic [1:0] pcs, tc, input logic [3:0] ir);
        return {st, imreq, irw, dreq, dwe, rw, wbs, alu, pcw, pcs, tc, ir};
    endfunction
    function automatic logic [19:0] e_idle(input logic [1:0] tc, input logic [3:0] ir);
        return ov(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, tc, ir);
    endfunction
    function automatic logic [19:0] e_fetch(input logic ack, input logic [3:0] ir);
        return ov(3'd1, 1'b1, ack, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, ir);
    endfunction
    function automatic logic [19:0] e_dec(input logic [3:0] ir);
        return ov(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, ir);
    endfunction
    function automatic logic [19:0] e_exe(input logic alu, pcw, input logic [1:0] pcs, input logic [3:0] ir);
        return ov(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, alu, pcw, pcs, 2'd0, ir);
    endfunction
    function automatic logic [19:0] e_mem(input logic we, pcw, input logic [3:0] ir);
        return ov(3'd4, 1'b0, 1'b0, 1'b1, we, 1'b0, 2'd0, 1'b0, pcw, 2'd0, 2'd0, ir);
    endfunction
    function automatic logic [19:0] e_wb(input logic [1:0] wbs, pcs, input logic [3:0] ir);
        return ov(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wbs, 1'b0, 1'b1, pcs, 2'd0, ir);
    endfunction
    function automatic logic [19:0] e_trap(input logic [1:0] tc, input logic [3:0] ir);
        return ov(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, tc, ir);
    endfunction

    task automatic push(input logic [4:0] ctl, input logic [31:0] instr, input logic [19:0] e);
        sb.push_back({ctl, instr, e});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {run, imem_ack, dmem_ack, branch_taken, clear_trap} = 5'b00000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step_t s;
        int i = 0;
        #3;
        n_checks++;
        if (obs !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs, 20'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(5'b00000, I_ADD, e_idle(2'd0, 4'd0));
        push(5'b00000, I_ADD, e_idle(2'd0, 4'd0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL reset_idle step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_op();
        step_t s;
        int i = 0;
        do_reset();
        push(5'b11100, I_ADD, e_idle(2'd0, 4'd0));
        push(5'b11100, I_ADD, e_fetch(1'b1, 4'd0));
        push(5'b11100, I_ADD, e_dec(4'd0));
        push(5'b11100, I_ADD, e_exe(1'b0, 1'b0, 2'b00, 4'd0));
        push(5'b11100, I_ADD, e_wb(2'b00, 2'b00, 4'd0));
        push(5'b00000, I_ADD, e_fetch(1'b0, 4'd1));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL op_add step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_load();
        step_t s;
        int i = 0;
        do_reset();
        push(5'b11000, I_LW, e_idle(2'd0, 4'd0));
        push(5'b11000, I_LW, e_fetch(1'b1, 4'd0));
        push(5'b11000, I_LW, e_dec(4'd0));
        push(5'b10000, I_LW, e_exe(1'b1, 1'b0, 2'b00, 4'd0));
        push(5'b00000, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        push(5'b00000, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        push(5'b00000, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        push(5'b00100, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        push(5'b00000, I_LW, e_wb(2'b01, 2'b00, 4'd0));
        push(5'b00000, I_LW, e_idle(2'd0, 4'd1));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL load_lw step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_branch_store();
        step_t s;
        int i = 0;
        do_reset();
        push(5'b11010, I_BEQ, e_idle(2'd0, 4'd0));
        push(5'b11010, I_BEQ, e_fetch(1'b1, 4'd0));
        push(5'b11010, I_BEQ, e_dec(4'd0));
        push(5'b11010, I_BEQ, e_exe(1'b0, 1'b1, 2'b01, 4'd0));
        push(5'b11000, I_BEQ, e_fetch(1'b1, 4'd1));
        push(5'b11000, I_BEQ, e_dec(4'd1));
        push(5'b00000, I_BEQ, e_exe(1'b0, 1'b1, 2'b00, 4'd1));
        push(5'b11100, I_SW, e_idle(2'd0, 4'd2));
        push(5'b11100, I_SW, e_fetch(1'b1, 4'd2));
        push(5'b11100, I_SW, e_dec(4'd2));
        push(5'b11100, I_SW, e_exe(1'b1, 1'b0, 2'b00, 4'd2));
        push(5'b00100, I_SW, e_mem(1'b1, 1'b1, 4'd2));
        push(5'b00000, I_SW, e_idle(2'd0, 4'd3));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL branch_store step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        logic [31:0] bad [5] = '{32'h0000007F, 32'h00001067, 32'h00003003, 32'h00006003, 32'h00003023};
        for (int k = 0; k < 5; k++) begin
            int i = 0;
            do_reset();
            push(5'b11000, bad[k], e_idle(2'd0, 4'd0));
            push(5'b11000, bad[k], e_fetch(1'b1, 4'd0));
            push(5'b11000, bad[k], e_dec(4'd0));
            push(5'b00000, bad[k], e_trap(2'd1, 4'd0));
            push(5'b10000, bad[k], e_trap(2'd1, 4'd0));
            push(5'b10001, bad[k], e_trap(2'd1, 4'd0));
            push(5'b00000, bad[k], e_idle(2'd0, 4'd0));
            while (sb.size() > 0) begin
                s = sb.pop_front();
                @(negedge clk);
                {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
                opcode = s.instr[6:0]; func3 = s.instr[14:12];
                #1;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL illegal_%0d step %0d: got %h expected %h", k, i, obs, s.exp);
                end
                i++;
            end
        end
    endtask

    task automatic test_timeout();
        step_t s;
        int i = 0;
        do_reset();
        push(5'b10000, I_LW, e_idle(2'd0, 4'd0));
        for (int k = 0; k < 4; k++) push(5'b10000, I_LW, e_fetch(1'b0, 4'd0));
        push(5'b10001, I_LW, e_trap(2'd2, 4'd0));
        push(5'b11000, I_LW, e_idle(2'd0, 4'd0));
        push(5'b11000, I_LW, e_fetch(1'b1, 4'd0));
        push(5'b10000, I_LW, e_dec(4'd0));
        push(5'b10000, I_LW, e_exe(1'b1, 1'b0, 2'b00, 4'd0));
        push(5'b10000, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL imem_timeout step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mem: got %h expected %h", obs, 20'd0);
        end
        i = 0;
        do_reset();
        push(5'b11000, I_LW, e_idle(2'd0, 4'd0));
        push(5'b11000, I_LW, e_fetch(1'b1, 4'd0));
        push(5'b10000, I_LW, e_dec(4'd0));
        push(5'b10000, I_LW, e_exe(1'b1, 1'b0, 2'b00, 4'd0));
        for (int k = 0; k < 4; k++) push(5'b10000, I_LW, e_mem(1'b0, 1'b0, 4'd0));
        push(5'b10001, I_LW, e_trap(2'd3, 4'd0));
        push(5'b00000, I_LW, e_idle(2'd0, 4'd0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL dmem_timeout step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    task automatic test_jump_wrap();
        step_t s;
        int i = 0;
        do_reset();
        push(5'b11000, I_BEQ, e_idle(2'd0, 4'd0));
        for (int k = 0; k < 15; k++) begin
            push(5'b11000, I_BEQ, e_fetch(1'b1, 4'(k)));
            push(5'b11000, I_BEQ, e_dec(4'(k)));
            push((k < 14) ? 5'b11000 : 5'b01000, I_BEQ, e_exe(1'b0, 1'b1, 2'b00, 4'(k)));
        end
        push(5'b11000, I_JAL, e_idle(2'd0, 4'd15));
        push(5'b11000, I_JAL, e_fetch(1'b1, 4'd15));
        push(5'b01000, I_JAL, e_dec(4'd15));
        push(5'b01000, I_JAL, e_exe(1'b1, 1'b0, 2'b00, 4'd15));
        push(5'b00000, I_JAL, e_wb(2'b10, 2'b01, 4'd15));
        push(5'b11000, I_JALR, e_idle(2'd0, 4'd0));
        push(5'b11000, I_JALR, e_fetch(1'b1, 4'd0));
        push(5'b11000, I_JALR, e_dec(4'd0));
        push(5'b11000, I_JALR, e_exe(1'b1, 1'b0, 2'b00, 4'd0));
        push(5'b00000, I_JALR, e_wb(2'b10, 2'b10, 4'd0));
        push(5'b00000, I_JALR, e_idle(2'd0, 4'd1));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            {run, imem_ack, dmem_ack, branch_taken, clear_trap} = s.ctl;
            opcode = s.instr[6:0]; func3 = s.instr[14:12];
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL jump_wrap step %0d: got %h expected %h", i, obs, s.exp);
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_op();
        test_load();
        test_branch_store();
        test_illegal();
        test_timeout();
        test_jump_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
